// File: rtl/nlp_pkg.sv
// Shared NLP constants: data width, Q.16 fraction, window length, FSM codes.
package nlp_pkg;
  localparam int N = 80;
  localparam int FRAC = 16;
  localparam int NLP_WIN_LEN = 64;
  localparam int IDX_W = 6;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;
endpackage

// File: rtl/nlp_window_apply_if.sv
// Buffer/ROM/DFT-buffer bus of the NLP window stage.
interface nlp_window_apply_if;
  import nlp_pkg::*;
  logic             start;
  logic [IDX_W-1:0] sample_addr;
  logic [N-1:0]     sample_in;
  logic [IDX_W-1:0] w_addr;
  logic [N-1:0]     w_in;
  logic [IDX_W-1:0] out_addr;
  logic [N-1:0]     out_data;
  logic             out_we;
  logic             busy;
  logic             done;

  modport master (
    output start, sample_in, w_in,
    input  sample_addr, w_addr, out_addr,
    input  out_data, out_we, busy, done
  );

  modport slave (
    input  start, sample_in, w_in,
    output sample_addr, w_addr, out_addr,
    output out_data, out_we, busy, done
  );
endinterface

// File: rtl/fpmul_q16.sv
// Signed Q.16 multiply, full product then shift by FRAC.
// Define NLP_WIN_ROUND_EN for round-half-up, otherwise truncation.
module fpmul_q16
  import nlp_pkg::*;
(
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  localparam logic signed [2*N-1:0] HALF =
    (2*N)'(1) << (FRAC-1);

  logic signed [2*N-1:0] p;
  logic signed [2*N-1:0] pr;
  logic                  unused_bits;

  assign p = (2*N)'($signed(a)) * (2*N)'($signed(b));

`ifdef NLP_WIN_ROUND_EN
  assign pr = p + HALF;
`else
  assign pr = p;
`endif

  // Taking bits [FRAC +: N] is the arithmetic shift kept to N bits.
  assign y = pr[FRAC +: N];
  assign unused_bits = ^{pr[FRAC-1:0], pr[2*N-1:N+FRAC]};
endmodule

// File: rtl/nlp_window_apply.sv
// NLP analysis window: 64 samples times ROM taps into the DFT buffer.
// Rounding of the product follows NLP_WIN_ROUND_EN (see fpmul_q16).
module nlp_window_apply
  import nlp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  nlp_window_apply_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NLP_WIN_LEN-1);

  logic [2:0]       state;
  logic [IDX_W-1:0] i;
  logic [IDX_W-1:0] wa;
  logic [N-1:0]     r;
  logic [N-1:0]     prod;
  logic             rd;

  fpmul_q16 u_mul (
    .a (bus.sample_in),
    .b (bus.w_in),
    .y (prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      i     <= '0;
      wa    <= '0;
      r     <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.start) begin
          state <= S_ADDR;
          i     <= '0;
        end
        S_ADDR: state <= S_MUL;
        S_MUL: begin
          r     <= prod;
          wa    <= i;
          state <= S_WR;
        end
        S_WR: if (i == LAST) begin
          state <= S_FIN;
        end else begin
          i     <= i + 1'b1;
          state <= S_ADDR;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write address/data are registered so they hold between strobes.
  assign rd              = (state == S_ADDR) || (state == S_MUL);
  assign bus.sample_addr = rd ? i : '0;
  assign bus.w_addr      = rd ? i : '0;
  assign bus.out_addr    = wa;
  assign bus.out_data    = r;
  assign bus.out_we      = (state == S_WR);
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_FIN);
endmodule

// File: tb/tb_nlp_window_apply.sv
// Directed and random frames checked against a floor-division model.
module tb_nlp_window_apply;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  nlp_window_apply_if bus ();

  nlp_window_apply dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [79:0] smem [64];
  logic [79:0] wrom [64];
  logic [79:0] expo [64];

  assign bus.w_in = wrom[bus.w_addr];
  always @(posedge clk) bus.sample_in <= smem[bus.sample_addr];

  int total = 0;
  int bad = 0;
  int busy_err = 0;
  int hold_err = 0;
  bit have_last = 0;
  logic [79:0] last_d;
  logic [5:0]  last_a;

  logic [5:0]  wr_addr [$];
  logic [79:0] wr_data [$];
  int          wr_cyc  [$];
  int          done_cyc [$];

  localparam logic [79:0] MAXP = {1'b0, {79{1'b1}}};

  function automatic logic [79:0] model(logic signed [79:0] s,
                                        logic signed [79:0] w);
    logic signed [159:0] p;
    logic signed [159:0] q;
    p = 160'(s) * 160'(w);
`ifdef NLP_WIN_ROUND_EN
    p = p + 160'sd32768;
`endif
    q = p / 160'sd65536;
    if (p < 0 && (p % 160'sd65536) != 0) q = q - 1;
    return q[79:0];
  endfunction

  task automatic chk(string tag, logic [79:0] obs, logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic calc_exp();
    for (int k = 0; k < 64; k++) expo[k] = model(smem[k], wrom[k]);
  endtask

  task automatic fill(logic [79:0] v);
    for (int k = 0; k < 64; k++) smem[k] = v;
  endtask

  task automatic run_frame(int len, int p1, int p2, int rst_at);
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
    calc_exp();
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (bus.out_we) begin
        wr_addr.push_back(bus.out_addr);
        wr_data.push_back(bus.out_data);
        wr_cyc.push_back(c);
        last_a = bus.out_addr;
        last_d = bus.out_data;
        have_last = 1;
      end else if (have_last && rst) begin
        if (bus.out_data !== last_d || bus.out_addr !== last_a)
          hold_err++;
      end
      if (bus.done) done_cyc.push_back(c);
      if (rst_at < 0 || c < rst_at)
        if (bus.busy !== (c >= 1 && c <= 193)) busy_err++;
      bus.start = (c == 0 || c == p1 || c == p2);
      if (c == rst_at) begin
        rst = 1'b0;
        have_last = 0;
        #1;
        chk("rst_we", 80'(bus.out_we), 80'd0);
        chk("rst_busy", 80'(bus.busy), 80'd0);
        chk("rst_data", bus.out_data, 80'd0);
        chk("rst_oaddr", 80'(bus.out_addr), 80'd0);
        chk("rst_saddr", 80'(bus.sample_addr), 80'd0);
      end
      if (rst_at >= 0 && c == rst_at + 3) rst = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_frame(string tag);
    chk({tag, "_nwr"}, 80'(wr_addr.size()), 80'd64);
    chk({tag, "_ndone"}, 80'(done_cyc.size()), 80'd1);
    if (done_cyc.size() > 0)
      chk({tag, "_donecyc"}, 80'(done_cyc[0]), 80'd193);
    for (int k = 0; k < 64 && k < wr_addr.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), 80'(wr_addr[k]), 80'(k));
      chk($sformatf("%s_cyc%0d", tag, k), 80'(wr_cyc[k]), 80'(3 + 3 * k));
      chk($sformatf("%s_data%0d", tag, k), wr_data[k], expo[k]);
    end
  endtask

  function automatic logic [79:0] rnd80();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  initial begin
    bus.start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      wrom[k] = 80'($urandom_range(0, 'hFFD7));
      smem[k] = '0;
    end
    wrom[0]  = '0;
    wrom[63] = '0;
    wrom[21] = 80'hC000;
    wrom[31] = 80'hFFD7;

    repeat (3) @(negedge clk);
    chk("init_we", 80'(bus.out_we), 80'd0);
    chk("init_busy", 80'(bus.busy), 80'd0);
    chk("init_done", 80'(bus.done), 80'd0);
    chk("init_data", bus.out_data, 80'd0);
    chk("init_oaddr", 80'(bus.out_addr), 80'd0);
    chk("init_saddr", 80'(bus.sample_addr), 80'd0);
    chk("init_waddr", 80'(bus.w_addr), 80'd0);
    rst = 1'b1;
    @(negedge clk);

    fill(80'h10000);
    run_frame(200, -1, -1, -1);
    check_frame("unit");
    if (wr_data.size() == 64) begin
      chk("unit_o0", wr_data[0], 80'd0);
      chk("unit_o21", wr_data[21], 80'hC000);
      chk("unit_o31", wr_data[31], 80'hFFD7);
      chk("unit_o63", wr_data[63], 80'd0);
    end

    fill('0);
    smem[21] = -80'sh10000;
    run_frame(200, -1, -1, -1);
    check_frame("neg");
    if (wr_data.size() == 64) begin
      chk("neg_o21", wr_data[21], 80'hFFFF_FFFF_FFFF_FFFF_4000);
      chk("neg_o20", wr_data[20], 80'd0);
    end

    fill('0);
    smem[21] = 80'd1;
    run_frame(200, -1, -1, -1);
    check_frame("rndp");
    if (wr_data.size() == 64) begin
`ifdef NLP_WIN_ROUND_EN
      chk("rndp_o21", wr_data[21], 80'd1);
`else
      chk("rndp_o21", wr_data[21], 80'd0);
`endif
    end

    smem[21] = '1;
    run_frame(200, -1, -1, -1);
    check_frame("rndn");
    if (wr_data.size() == 64)
      chk("rndn_o21", wr_data[21], '1);

    fill('0);
    smem[0]  = MAXP;
    smem[31] = MAXP;
    smem[63] = MAXP;
    run_frame(200, -1, -1, -1);
    check_frame("edge");
    if (wr_data.size() == 64) begin
      chk("edge_o0", wr_data[0], 80'd0);
      chk("edge_o63", wr_data[63], 80'd0);
      chk("edge_sign31", 80'(wr_data[31][79]), 80'd0);
    end

    for (int k = 0; k < 64; k++) smem[k] = rnd80();
    run_frame(194, 50, 193, -1);
    check_frame("busy1");
    for (int k = 0; k < 64; k++) smem[k] = rnd80();
    run_frame(200, -1, -1, -1);
    check_frame("busy2");

    for (int k = 0; k < 64; k++) smem[k] = rnd80();
    run_frame(110, -1, -1, 100);
    chk("midrst_nwr", 80'(wr_addr.size()), 80'd33);
    if (wr_cyc.size() > 0)
      chk("midrst_lastcyc", 80'(wr_cyc[wr_cyc.size()-1]), 80'd99);
    for (int k = 0; k < 64; k++) smem[k] = rnd80();
    run_frame(200, -1, -1, -1);
    check_frame("postrst");

    chk("busy_track", 80'(busy_err), 80'd0);
    chk("out_hold", 80'(hold_err), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
